// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, opcodes, encodings and fetch FSM state type
package cpu_pkg;

   localparam int PC_W   = 16;
   localparam int INST_W = 16;

   localparam logic [PC_W-1:0]   RESET_PC = 16'h0000;
   localparam logic [3:0]        HALT_OP  = 4'h1;
   localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } fetch_state_t;

   // Opcode lives in the top nibble of the instruction word
   function automatic logic is_halt(input logic [INST_W-1:0] inst);
      return inst[INST_W-1 -: 4] == HALT_OP;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory bus plus IF/ID register outputs
interface fetch_stage_if;
   import cpu_pkg::*;

   logic              imem_en;
   logic [PC_W-1:0]   imem_addr;
   logic [INST_W-1:0] imem_rdata;
   logic              if_valid;
   logic [INST_W-1:0] if_inst;
   logic [PC_W-1:0]   if_pc;

   modport master (
      output imem_en, imem_addr, if_valid, if_inst, if_pc,
      input  imem_rdata
   );

   modport slave (
      input  imem_en, imem_addr, if_valid, if_inst, if_pc,
      output imem_rdata
   );

endinterface

// File: rtl/if_skid_buf.sv
// rtl/if_skid_buf.sv - one-entry {inst,pc} holding register for reads landing during a stall
module if_skid_buf
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic              i_drain,
   input  logic              i_flush,
   input  logic [INST_W-1:0] i_inst,
   input  logic [PC_W-1:0]   i_pc,
   output logic              o_vld,
   output logic [INST_W-1:0] o_inst,
   output logic [PC_W-1:0]   o_pc
);

   logic              r_vld;
   logic [INST_W-1:0] r_inst;
   logic [PC_W-1:0]   r_pc;

   // Flush beats load beats drain; a load during drain refills the entry with the newer read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld  <= 1'b0;
         r_inst <= NOP_INST;
         r_pc   <= '0;
      end else if (i_flush) begin
         r_vld  <= 1'b0;
      end else if (i_load) begin
         r_vld  <= 1'b1;
         r_inst <= i_inst;
         r_pc   <= i_pc;
      end else if (i_drain) begin
         r_vld  <= 1'b0;
      end
   end

   assign o_vld  = r_vld;
   assign o_inst = r_inst;
   assign o_pc   = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, imem request, IF/ID register, stall skid, redirect and HALT; FETCH_PERF_EN adds perf counters
module fetch_stage
   import cpu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             redirect,
   input  logic [PC_W-1:0]  redirect_pc,
   fetch_stage_if.master    bus,
   output logic             halted,
   output logic [31:0]      perf_fetch_cnt,
   output logic [31:0]      perf_stall_cnt
);

   fetch_state_t      r_state, w_state_nxt;
   logic [PC_W-1:0]   r_pc, w_pc_nxt;
   logic              r_req_vld, w_req_vld_nxt;
   logic [PC_W-1:0]   r_req_pc, w_req_pc_nxt;
   logic              r_if_valid, w_if_valid_nxt;
   logic [INST_W-1:0] r_if_inst, w_if_inst_nxt;
   logic [PC_W-1:0]   r_if_pc, w_if_pc_nxt;

   logic              w_imem_en;
   logic [PC_W-1:0]   w_imem_addr;
   logic              w_load_valid;
   logic              w_skid_load, w_skid_drain, w_skid_flush;
   logic              w_skid_vld;
   logic [INST_W-1:0] w_skid_inst;
   logic [PC_W-1:0]   w_skid_pc;

   if_skid_buf u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_skid_load),
      .i_drain (w_skid_drain),
      .i_flush (w_skid_flush),
      .i_inst  (bus.imem_rdata),
      .i_pc    (r_req_pc),
      .o_vld   (w_skid_vld),
      .o_inst  (w_skid_inst),
      .o_pc    (w_skid_pc)
   );

   // Next-state, imem request and IF/ID load selection; redirect > halted > stall > normal
   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_req_vld_nxt  = r_req_vld;
      w_req_pc_nxt   = r_req_pc;
      w_if_valid_nxt = r_if_valid;
      w_if_inst_nxt  = r_if_inst;
      w_if_pc_nxt    = r_if_pc;
      w_imem_en      = 1'b0;
      w_imem_addr    = r_pc;
      w_load_valid   = 1'b0;
      w_skid_load    = 1'b0;
      w_skid_drain   = 1'b0;
      w_skid_flush   = 1'b0;

      if (redirect) begin
         // Everything fetched down the old path is dropped, including the skid entry
         w_imem_en      = 1'b1;
         w_imem_addr    = redirect_pc;
         w_pc_nxt       = redirect_pc + PC_W'(1);
         w_req_pc_nxt   = redirect_pc;
         w_req_vld_nxt  = 1'b1;
         w_skid_flush   = 1'b1;
         w_if_valid_nxt = 1'b0;
         w_if_inst_nxt  = NOP_INST;
         w_state_nxt    = ST_RUN;
      end else if (r_state == ST_HALTED) begin
         // HALT stays visible while decode stalls, then becomes a bubble
         w_req_vld_nxt = 1'b0;
         w_skid_flush  = 1'b1;
         if (!stall) begin
            w_if_valid_nxt = 1'b0;
            w_if_inst_nxt  = NOP_INST;
         end
      end else if (stall) begin
         // Park the read that is landing now so it is not lost while IF/ID holds
         if (r_req_vld) begin
            w_skid_load   = 1'b1;
            w_req_vld_nxt = 1'b0;
         end
      end else begin
         w_imem_en     = 1'b1;
         w_imem_addr   = r_pc;
         w_pc_nxt      = r_pc + PC_W'(1);
         w_req_vld_nxt = 1'b1;
         w_req_pc_nxt  = r_pc;
         if (w_skid_vld) begin
            // Skid holds the older instruction; any read landing now queues behind it
            w_if_valid_nxt = 1'b1;
            w_if_inst_nxt  = w_skid_inst;
            w_if_pc_nxt    = w_skid_pc;
            w_load_valid   = 1'b1;
            w_skid_drain   = 1'b1;
            w_skid_load    = r_req_vld;
         end else if (r_req_vld) begin
            w_if_valid_nxt = 1'b1;
            w_if_inst_nxt  = bus.imem_rdata;
            w_if_pc_nxt    = r_req_pc;
            w_load_valid   = 1'b1;
         end else begin
            w_if_valid_nxt = 1'b0;
            w_if_inst_nxt  = NOP_INST;
         end
         if (w_load_valid && is_halt(w_if_inst_nxt)) begin
            w_state_nxt = ST_HALTED;
         end
      end
   end

   // State, PC, outstanding request and IF/ID registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_RUN;
         r_pc       <= RESET_PC;
         r_req_vld  <= 1'b0;
         r_req_pc   <= '0;
         r_if_valid <= 1'b0;
         r_if_inst  <= NOP_INST;
         r_if_pc    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_req_vld  <= w_req_vld_nxt;
         r_req_pc   <= w_req_pc_nxt;
         r_if_valid <= w_if_valid_nxt;
         r_if_inst  <= w_if_inst_nxt;
         r_if_pc    <= w_if_pc_nxt;
      end
   end

   assign bus.imem_en   = w_imem_en;
   assign bus.imem_addr = w_imem_addr;
   assign bus.if_valid  = r_if_valid;
   assign bus.if_inst   = r_if_valid ? r_if_inst : NOP_INST;
   assign bus.if_pc     = r_if_pc;
   assign halted        = (r_state == ST_HALTED);

`ifdef FETCH_PERF_EN
   logic [31:0] r_perf_fetch;
   logic [31:0] r_perf_stall;

   // Delivered-instruction and stall-cycle counters, free-running with natural wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_fetch <= '0;
         r_perf_stall <= '0;
      end else begin
         if (w_load_valid)         r_perf_fetch <= r_perf_fetch + 32'd1;
         if (stall && !redirect)   r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign perf_fetch_cnt = r_perf_fetch;
   assign perf_stall_cnt = r_perf_stall;
`else
   assign perf_fetch_cnt = '0;
   assign perf_stall_cnt = '0;
`endif

endmodule
